regfile: RTL and testbench

- General-purpose register file serving the decode stage's two read requests: reg0 (rt) and reg1 (rs).
- Accepts one write per cycle from the write-back stage.
- Contents live in a RAM-style array. It is cleared after reset by a sweep state machine rather than a bulk reset.
- Read data is combinational, with same-cycle write-to-read bypass, so decode sees a result written back in the current cycle.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_rd_port.sv | 51 +++++
 rtl/regfile.sv | 138 +++++++++++++
 tb/tb_regfile.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared defines for the general-purpose register file: default geometry,
//   the all-zero word, the hard-wired zero register index and the clear-sweep
//   state encoding.
package regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_DATA_W-1:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = 5'd0;

  // INIT: clear sweep in progress, file unusable. READY: normal operation.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_rd_port.sv
// regfile_rd_port
//   One combinational read port of the register file: forces zero while in
//   reset, while the clear sweep runs, when the port is idle or when r0 is
//   addressed; otherwise forwards a same-cycle write or the stored word.
// Ports:
//   rst        synchronous reset of the file (reads return zero while high)
//   ready      file has finished its clear sweep
//   rd_en      read enable for this port
//   rd_addr    register index for this port
//   we/waddr/wdata  write-back request of the current cycle (bypass source)
//   mem_rdata  array contents at rd_addr
//   rd_data    read result
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              rst,
  input  logic              ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(NOP_REG_ADDR);

  // Prioritised read mux: zero cases first, then bypass, then the array.
  always_comb begin
    rd_data = {DATA_W{1'b0}};
    if (rst) begin
      rd_data = {DATA_W{1'b0}};
    end else if (!ready) begin
      rd_data = {DATA_W{1'b0}};
    end else if (!rd_en) begin
      rd_data = {DATA_W{1'b0}};
    end else if (rd_addr == ZERO_ADDR) begin
      rd_data = {DATA_W{1'b0}};
    end else if (we && (waddr == rd_addr)) begin
      // waddr is nonzero here because rd_addr is nonzero.
      rd_data = wdata;
    end else begin
      rd_data = mem_rdata;
    end
  end

endmodule : regfile_rd_port

// File: rtl/regfile.sv
// regfile
//   General-purpose register file with two combinational read ports and one
//   write port. The array has no reset; after rst a sweep FSM writes zero to
//   r1..r(NUM_REGS-1), one register per cycle, then raises init_done.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   we, waddr, wdata         write-back request (dropped during the sweep and for r0)
//   reg0_read/addr/data      decode read port 0 (rt)
//   reg1_read/addr/data      decode read port 1 (rs)
//   init_done                high once the clear sweep has completed
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              reg0_read,
  input  logic [ADDR_W-1:0] reg0_addr,
  output logic [DATA_W-1:0] reg0_data,
  input  logic              reg1_read,
  input  logic [ADDR_W-1:0] reg1_addr,
  output logic [DATA_W-1:0] reg1_data,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(NOP_REG_ADDR);
  localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              init_done_q, init_done_d;

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              ready_s;

  // Sweep FSM next state and selection of the single array write per cycle.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    init_done_d = init_done_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = clr_ptr_q;
    mem_wdata_s = {DATA_W{1'b0}};
    case (state_q)
      ST_INIT: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_ptr_q;
        mem_wdata_s = {DATA_W{1'b0}};
        if (clr_ptr_q == LAST_PTR) begin
          // Hold the pointer so it never wraps into r0.
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q + FIRST_PTR;
        end
      end
      ST_READY: begin
        if (we && (waddr != ZERO_ADDR)) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = waddr;
          mem_wdata_s = wdata;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        state_d     = ST_INIT;
        clr_ptr_d   = FIRST_PTR;
        init_done_d = 1'b0;
      end
    endcase
  end

  // Control state registers; reset restarts the sweep at r1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      clr_ptr_q   <= FIRST_PTR;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      init_done_q <= init_done_d;
    end
  end

  // Register array; reset blocks any write that coincides with it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign ready_s   = (state_q == ST_READY);
  assign init_done = init_done_q;

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port0 (
    .rst       (rst),
    .ready     (ready_s),
    .rd_en     (reg0_read),
    .rd_addr   (reg0_addr),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .mem_rdata (mem_q[reg0_addr]),
    .rd_data   (reg0_data)
  );

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port1 (
    .rst       (rst),
    .ready     (ready_s),
    .rd_en     (reg1_read),
    .rd_addr   (reg1_addr),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .mem_rdata (mem_q[reg1_addr]),
    .rd_data   (reg1_data)
  );

endmodule : regfile

// File: tb/tb_regfile.sv
// tb_regfile
//   Self-checking bench for regfile: directed scenarios plus randomized
//   traffic compared against a behavioural model (array of words, a
//   countdown for the clear period and the read rules as plain conditions).
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        reg0_read;
  logic [4:0]  reg0_addr;
  logic [31:0] reg0_data;
  logic        reg1_read;
  logic [4:0]  reg1_addr;
  logic [31:0] reg1_data;
  logic        init_done;

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [31:0] model [32];
  bit          m_ready = 1'b0;
  int          m_cnt   = 31;

  always #5 clk = ~clk;

  regfile dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .reg0_read (reg0_read),
    .reg0_addr (reg0_addr),
    .reg0_data (reg0_data),
    .reg1_read (reg1_read),
    .reg1_addr (reg1_addr),
    .reg1_data (reg1_data),
    .init_done (init_done)
  );

  function automatic logic [31:0] exp_rd(input logic rd, input logic [4:0] a);
    if (rst || !m_ready || !rd || a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return model[a];
  endfunction

  // One clock: apply edge semantics to the model, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      m_cnt   = 31;
      m_ready = 1'b0;
    end else if (!m_ready) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_ready = 1'b1;
    end else if (we && waddr != 5'd0) begin
      model[waddr] = wdata;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    reg0_read = 1'b0; reg0_addr = 5'd0;
    reg1_read = 1'b0; reg1_addr = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    reg0_read = 1'b1; reg0_addr = 5'd5;
    @(negedge clk);
    tick(); tick();
    #1;
    total++;
    if (init_done !== 1'b0 || reg0_data !== 32'h0) begin
      bad++; $display("FAIL reset_state init_done=%b data=%h required 0/0", init_done, reg0_data);
    end
    rst = 1'b0;
    for (int i = 0; i < 31; i++) begin
      we = (i == 3); waddr = 5'd5; wdata = 32'hDEADBEEF;
      #1;
      total++;
      if (init_done !== 1'b0) begin
        bad++; $display("FAIL sweep_init_done cyc=%0d got=%b required=0", i, init_done);
      end
      total++;
      if (reg0_data !== 32'h0) begin
        bad++; $display("FAIL sweep_read cyc=%0d got=%h required=0", i, reg0_data);
      end
      tick();
    end
    we = 1'b0;
    #1;
    total++;
    if (init_done !== 1'b1) begin
      bad++; $display("FAIL init_done_rise got=%b required=1", init_done);
    end
    total++;
    if (reg0_data !== 32'h0) begin
      bad++; $display("FAIL r5_after_sweep got=%h required=0", reg0_data);
    end
  endtask

  task automatic test_basic();
    idle_inputs();
    we = 1'b1; waddr = 5'd3; wdata = 32'h12345678;
    tick();
    idle_inputs();
    reg0_read = 1'b1; reg0_addr = 5'd3;
    reg1_read = 1'b0; reg1_addr = 5'd3;
    #1;
    total++;
    if (reg0_data !== 32'h12345678) begin
      bad++; $display("FAIL basic_rd0 got=%h required=12345678", reg0_data);
    end
    total++;
    if (reg1_data !== 32'h0) begin
      bad++; $display("FAIL basic_rd1_disabled got=%h required=0", reg1_data);
    end
    tick();
  endtask

  task automatic test_bypass();
    idle_inputs();
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    reg0_read = 1'b1; reg0_addr = 5'd7;
    reg1_read = 1'b1; reg1_addr = 5'd7;
    #1;
    total++;
    if (reg0_data !== 32'hA5A5A5A5 || reg1_data !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL bypass_same_cycle got=%h/%h required=a5a5a5a5", reg0_data, reg1_data);
    end
    tick();
    we = 1'b0; wdata = 32'h0;
    #1;
    total++;
    if (reg0_data !== 32'hA5A5A5A5 || reg1_data !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL bypass_persist got=%h/%h required=a5a5a5a5", reg0_data, reg1_data);
    end
    tick();
  endtask

  task automatic test_r0();
    idle_inputs();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    reg0_read = 1'b1; reg1_read = 1'b1;
    #1;
    total++;
    if (reg0_data !== 32'h0 || reg1_data !== 32'h0) begin
      bad++; $display("FAIL r0_bypass got=%h/%h required=0", reg0_data, reg1_data);
    end
    tick();
    we = 1'b0;
    #1;
    total++;
    if (reg0_data !== 32'h0 || reg1_data !== 32'h0) begin
      bad++; $display("FAIL r0_read got=%h/%h required=0", reg0_data, reg1_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 31; i++) begin
      #1;
      total++;
      if (init_done !== 1'b0) begin
        bad++; $display("FAIL mid_reset_init_done cyc=%0d got=%b required=0", i, init_done);
      end
      tick();
    end
    #1;
    total++;
    if (init_done !== 1'b1) begin
      bad++; $display("FAIL mid_reset_rise got=%b required=1", init_done);
    end
  endtask

  task automatic test_collision();
    logic [31:0] vals [32];
    idle_inputs();
    for (int r = 1; r < 32; r++) begin
      vals[r] = $urandom | 32'h1;
      we = 1'b1; waddr = 5'(r); wdata = vals[r];
      tick();
    end
    idle_inputs();
    for (int r = 1; r < 32; r++) begin
      reg0_read = 1'b1; reg0_addr = 5'(r);
      #1;
      total++;
      if (reg0_data !== vals[r]) begin
        bad++; $display("FAIL fill_read r%0d got=%h required=%h", r, reg0_data, vals[r]);
      end
      tick();
    end
    rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h55;
    reg0_read = 1'b1; reg0_addr = 5'd9;
    #1;
    total++;
    if (reg0_data !== 32'h0) begin
      bad++; $display("FAIL collision_cycle_read got=%h required=0", reg0_data);
    end
    tick();
    rst = 1'b0; we = 1'b0;
    repeat (31) tick();
    for (int r = 1; r < 32; r++) begin
      reg1_read = 1'b1; reg1_addr = 5'(r);
      #1;
      total++;
      if (reg1_data !== 32'h0) begin
        bad++; $display("FAIL cleared_read r%0d got=%h required=0", r, reg1_data);
      end
      tick();
    end
  endtask

  task automatic test_max_index();
    idle_inputs();
    we = 1'b1; waddr = 5'd31; wdata = 32'h80000001;
    tick();
    idle_inputs();
    reg1_read = 1'b1; reg1_addr = 5'd31;
    reg0_read = 1'b1; reg0_addr = 5'd30;
    #1;
    total++;
    if (reg1_data !== 32'h80000001) begin
      bad++; $display("FAIL max_r31 got=%h required=80000001", reg1_data);
    end
    total++;
    if (reg0_data !== 32'h0) begin
      bad++; $display("FAIL max_r30 got=%h required=0", reg0_data);
    end
    tick();
    reg0_addr = 5'd1;
    #1;
    total++;
    if (reg0_data !== 32'h0) begin
      bad++; $display("FAIL max_r1 got=%h required=0", reg0_data);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] e0, e1;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      we        = $urandom_range(0, 1);
      waddr     = 5'($urandom_range(0, 31));
      wdata     = $urandom;
      reg0_read = ($urandom_range(0, 3) != 0);
      reg1_read = ($urandom_range(0, 3) != 0);
      reg0_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      reg1_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      #1;
      e0 = exp_rd(reg0_read, reg0_addr);
      e1 = exp_rd(reg1_read, reg1_addr);
      total++;
      if (reg0_data !== e0) begin
        bad++; $display("FAIL rand_rd0 it=%0d a=%0d got=%h required=%h", i, reg0_addr, reg0_data, e0);
      end
      total++;
      if (reg1_data !== e1) begin
        bad++; $display("FAIL rand_rd1 it=%0d a=%0d got=%h required=%h", i, reg1_addr, reg1_data, e1);
      end
      total++;
      if (init_done !== m_ready) begin
        bad++; $display("FAIL rand_init_done it=%0d got=%b required=%b", i, init_done, m_ready);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_r0();
    test_reset_mid();
    test_collision();
    test_max_index();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile
